// File: rtl/mhsa_pkg.sv
// Shared types and defaults for the MHSA host loader.
package mhsa_pkg;
    localparam int MHSA_WIDTH  = 64;
    localparam int MHSA_LENGTH = 4096;

    typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} loader_state_e;
endpackage

// File: rtl/mhsa_rd_fifo.sv
// Two-entry read-return FIFO between the SRAM read port and the host result stream.
module mhsa_rd_fifo #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_count
);
    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_pop;

    assign w_pop   = i_pop && (r_count != 2'd0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + {1'b0, i_push} - {1'b0, w_pop};
        end
    end
endmodule

// File: rtl/mhsa_host_loader.sv
// Host-side LOAD/RUN/DRAIN sequencer owning the unified SRAM bus.
// Optional XOR checksums of both streams: define MHSA_LOADER_CHECKSUM_EN.
module mhsa_host_loader
    import mhsa_pkg::*;
#(
    parameter int WIDTH  = MHSA_WIDTH,
    parameter int LENGTH = MHSA_LENGTH,
    localparam int CW    = $clog2(LENGTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CW-1:0]    in_words,
    input  logic [CW-1:0]    out_words,
    input  logic [31:0]      input_base,
    input  logic [31:0]      output_base,
    output logic             busy,
    output logic             done,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             acc_start,
    input  logic             acc_done,
    input  logic             acc_write_en,
    input  logic [31:0]      acc_addr,
    input  logic [WIDTH-1:0] acc_data_in,
    output logic [WIDTH-1:0] acc_data_out,
    output logic             sram_write_en,
    output logic [31:0]      sram_addr,
    output logic [WIDTH-1:0] sram_data_in,
    input  logic [WIDTH-1:0] sram_data_out
`ifdef MHSA_LOADER_CHECKSUM_EN
    ,
    output logic [WIDTH-1:0] in_csum,
    output logic [WIDTH-1:0] out_csum
`endif
);
    loader_state_e    r_state, w_next;
    logic [CW-1:0]    r_in_words, r_out_words, r_loaded, r_issued, r_delivered;
    logic [31:0]      r_in_base, r_out_base, r_addr_hold;
    logic [WIDTH-1:0] r_data_hold;
    logic             r_inflight, r_acc_done_q, r_run_seen;
    logic             w_accept, w_load_hs, w_issue, w_pop, w_acc_rise, w_wr;
    logic [1:0]       w_fifo_count;
    logic [31:0]      w_addr;
    logic [WIDTH-1:0] w_wdata;

    assign w_accept     = (r_state == IDLE) && start;
    assign in_ready     = (r_state == LOAD) && (r_loaded < r_in_words);
    assign w_load_hs    = in_valid && in_ready;
    assign out_valid    = (w_fifo_count != 2'd0);
    assign w_pop        = out_valid && out_ready;
    // Counting a same-cycle pop as a free slot keeps reads back-to-back.
    assign w_issue      = (r_state == DRAIN) && (r_issued < r_out_words) &&
                          (({1'b0, w_fifo_count} + {2'b0, r_inflight} - {2'b0, w_pop}) < 3'd2);
    assign w_acc_rise   = (r_state == RUN) && acc_done && !r_acc_done_q;
    assign acc_start    = (r_state == RUN) && !r_run_seen;
    assign busy         = (r_state != IDLE);
    assign done         = (r_state == DONE);
    assign acc_data_out = sram_data_out;

    mhsa_rd_fifo #(.WIDTH(WIDTH)) u_rd_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_inflight),
        .i_data  (sram_data_out),
        .i_pop   (w_pop),
        .o_data  (out_data),
        .o_count (w_fifo_count)
    );

    always_comb begin
        w_wr    = 1'b0;
        w_addr  = r_addr_hold;
        w_wdata = r_data_hold;
        if (w_load_hs) begin
            w_wr    = 1'b1;
            w_addr  = r_in_base + 32'(r_loaded);
            w_wdata = in_data;
        end else if (r_state == RUN) begin
            w_wr    = acc_write_en;
            w_addr  = acc_addr;
            w_wdata = acc_data_in;
        end else if (w_issue) begin
            w_addr  = r_out_base + 32'(r_issued);
        end
    end

    assign sram_write_en = w_wr;
    assign sram_addr     = w_addr;
    assign sram_data_in  = w_wdata;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = (in_words == '0) ? RUN : LOAD;
            LOAD:    if ((r_loaded == r_in_words) ||
                         (w_load_hs && (r_loaded + CW'(1) == r_in_words))) w_next = RUN;
            RUN:     if (w_acc_rise) w_next = DRAIN;
            DRAIN:   if ((r_delivered == r_out_words) ||
                         (w_pop && (r_delivered + CW'(1) == r_out_words))) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_in_words   <= '0;
            r_out_words  <= '0;
            r_in_base    <= '0;
            r_out_base   <= '0;
            r_loaded     <= '0;
            r_issued     <= '0;
            r_delivered  <= '0;
            r_addr_hold  <= '0;
            r_data_hold  <= '0;
            r_inflight   <= 1'b0;
            r_acc_done_q <= 1'b0;
            r_run_seen   <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_addr_hold  <= w_addr;
            r_data_hold  <= w_wdata;
            r_inflight   <= w_issue;
            // Cleared outside RUN so a level already high on entry reads as an edge.
            r_acc_done_q <= (r_state == RUN) && acc_done;
            r_run_seen   <= (r_state == RUN);
            if (w_accept) begin
                r_in_words  <= in_words;
                r_out_words <= out_words;
                r_in_base   <= input_base;
                r_out_base  <= output_base;
                r_loaded    <= '0;
                r_issued    <= '0;
                r_delivered <= '0;
            end else begin
                if (w_load_hs) r_loaded    <= r_loaded + CW'(1);
                if (w_issue)   r_issued    <= r_issued + CW'(1);
                if (w_pop)     r_delivered <= r_delivered + CW'(1);
            end
        end
    end

`ifdef MHSA_LOADER_CHECKSUM_EN
    logic [WIDTH-1:0] r_in_csum, r_out_csum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_csum  <= '0;
            r_out_csum <= '0;
        end else if (w_accept) begin
            r_in_csum  <= '0;
            r_out_csum <= '0;
        end else begin
            if (w_load_hs) r_in_csum  <= r_in_csum ^ in_data;
            if (w_pop)     r_out_csum <= r_out_csum ^ out_data;
        end
    end

    assign in_csum  = r_in_csum;
    assign out_csum = r_out_csum;
`endif
endmodule

// File: tb/tb_mhsa_host_loader.sv
// Scoreboard bench for mhsa_host_loader: table of full sequences plus reset-abort sequence.
`timescale 1ns/1ps
module tb_mhsa_host_loader;
    import mhsa_pkg::*;

    localparam int WIDTH  = 64;
    localparam int LENGTH = 4096;
    localparam int CW     = $clog2(LENGTH + 1);
    localparam int BUDGET = 6000;
    localparam logic [63:0] YW = 64'hACC0_0000_CAFE_F00D;
    localparam logic [63:0] ZW = 64'h5A5A_0000_1234_5678;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CW-1:0]    in_words, out_words;
    logic [31:0]      input_base, output_base;
    logic             busy, done, in_valid, in_ready, out_valid, out_ready;
    logic [WIDTH-1:0] in_data, out_data;
    logic             acc_start, acc_done, acc_write_en;
    logic [31:0]      acc_addr;
    logic [WIDTH-1:0] acc_data_in, acc_data_out;
    logic             sram_write_en;
    logic [31:0]      sram_addr;
    logic [WIDTH-1:0] sram_data_in, sram_data_out;
`ifdef MHSA_LOADER_CHECKSUM_EN
    logic [WIDTH-1:0] in_csum, out_csum;
`endif

    mhsa_host_loader #(.WIDTH(WIDTH), .LENGTH(LENGTH)) dut (
        .clk(clk), .rst(rst), .start(start), .in_words(in_words), .out_words(out_words),
        .input_base(input_base), .output_base(output_base), .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .acc_start(acc_start), .acc_done(acc_done), .acc_write_en(acc_write_en),
        .acc_addr(acc_addr), .acc_data_in(acc_data_in), .acc_data_out(acc_data_out),
        .sram_write_en(sram_write_en), .sram_addr(sram_addr), .sram_data_in(sram_data_in),
        .sram_data_out(sram_data_out)
`ifdef MHSA_LOADER_CHECKSUM_EN
        , .in_csum(in_csum), .out_csum(out_csum)
`endif
    );

    always #5 clk = ~clk;

    // SRAM model: 1024 words aliased on the low address bits, registered read.
    logic [WIDTH-1:0] mem [1024];
    logic             pl_en;
    logic [31:0]      pl_addr;
    logic [WIDTH-1:0] pl_data;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr[9:0]] <= pl_data;
        else if (sram_write_en) mem[sram_addr[9:0]] <= sram_data_in;
        sram_data_out <= mem[sram_addr[9:0]];
    end

    typedef struct packed { logic [31:0] addr; logic [63:0] data; } wr_t;
    wr_t         exp_wr[$];
    logic [63:0] exp_out[$];
    int          checks = 0;
    int          errors = 0;
    int          acc_start_total = 0;
    logic [31:0] last_wr_addr;
    logic        stall_q;
    logic [63:0] stall_data;
    wr_t         mon_w;
    logic [63:0] mon_d;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            stall_q = 1'b0;
        end else begin
            if (acc_start) acc_start_total++;
            if (sram_write_en) begin
                if (exp_wr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sram_write actual=%h:%h required=none", sram_addr, sram_data_in);
                end else begin
                    mon_w = exp_wr.pop_front();
                    check64("sram_addr", 64'(sram_addr), 64'(mon_w.addr));
                    check64("sram_data_in", sram_data_in, mon_w.data);
                end
                last_wr_addr = sram_addr;
            end
            if (stall_q && out_valid) check64("out_hold", out_data, stall_data);
            if (out_valid && out_ready) begin
                if (exp_out.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL out_word actual=%h required=none", out_data);
                end else begin
                    mon_d = exp_out.pop_front();
                    check64("out_data", out_data, mon_d);
                end
            end
            stall_q    = out_valid && !out_ready;
            stall_data = out_data;
        end
    end

    typedef struct {
        logic [CW-1:0] in_words;
        logic [CW-1:0] out_words;
        logic [31:0]   in_base;
        logic [31:0]   out_base;
        bit            toggle;
        bit            early;
        bit            pow2;
        int            exp_lat;
        logic [31:0]   exp_last_wr;
    } rec_t;

    function automatic rec_t mk(input int iw, input int ow, input logic [31:0] ib,
                                input logic [31:0] ob, input bit tg, input bit ea,
                                input bit p2, input int lat, input logic [31:0] lw);
        rec_t r;
        r.in_words = CW'(iw); r.out_words = CW'(ow); r.in_base = ib; r.out_base = ob;
        r.toggle = tg; r.early = ea; r.pow2 = p2; r.exp_lat = lat; r.exp_last_wr = lw;
        return r;
    endfunction

    task automatic preload(input logic [31:0] a, input logic [63:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check64({tag, "_ctrl"}, 64'({busy, done, in_ready, out_valid, acc_start, sram_write_en}), 64'd0);
        check64({tag, "_sram_addr"}, 64'(sram_addr), 64'd0);
        check64({tag, "_sram_data_in"}, sram_data_in, 64'd0);
        check64({tag, "_out_data"}, out_data, 64'd0);
    endtask

    task automatic run_seq(input rec_t r, input int idx);
        logic [63:0] words[$];
        logic [63:0] w, xi, xo;
        int n, m, widx, cyc, run_k, a0;
        bit seen_done;
        n = int'(r.in_words);
        m = int'(r.out_words);
        xi = '0; xo = '0;
        for (int i = 0; i < m; i++) begin
            w = 64'hD00D_0000_0000_0000 | (64'(idx) << 16) | 64'(i);
            preload(r.out_base + 32'(i), w);
            exp_out.push_back(w);
            xo ^= w;
        end
        if (!r.early) preload(32'h3A8, ZW);
        for (int i = 0; i < n; i++) begin
            w = r.pow2 ? (64'd1 << i) : {$urandom, $urandom};
            words.push_back(w);
            exp_wr.push_back({r.in_base + 32'(i), w});
            xi ^= w;
        end
        acc_done = r.early; acc_write_en = 1'b0; out_ready = 1'b1;
        last_wr_addr = 32'hDEAD_BEEF;
        a0 = acc_start_total;
        in_words = r.in_words; out_words = r.out_words;
        input_base = r.in_base; output_base = r.out_base;
        in_valid = 1'b1; in_data = (n > 0) ? words[0] : 64'hBAD0_BAD0_BAD0_BAD0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        in_words = '1; out_words = '1;
        cyc = 1; run_k = -1; widx = 0; seen_done = 0;
        while (!seen_done && cyc < BUDGET) begin
            @(negedge clk);
            if (cyc == 1) check64("busy_after_start", 64'(busy), 64'd1);
            if (in_valid && in_ready) widx++;
            if (acc_start && run_k < 0) run_k = 0;
            if (!r.early && run_k == 3) check64("acc_data_out", acc_data_out, ZW);
            if (done) begin
                seen_done = 1;
                if (r.exp_lat != 0) check64("done_latency", 64'(cyc), 64'(r.exp_lat));
                if (n != 0 || !r.early) check64("last_write_addr", 64'(last_wr_addr), 64'(r.exp_last_wr));
                check64("writes_left", 64'(exp_wr.size()), 64'd0);
                check64("outs_left", 64'(exp_out.size()), 64'd0);
`ifdef MHSA_LOADER_CHECKSUM_EN
                check64("in_csum", in_csum, xi);
                check64("out_csum", out_csum, xo);
                if (r.pow2) check64("in_csum_pow2", in_csum, 64'd7);
`endif
            end else begin
                @(posedge clk); #1;
                cyc++;
                start = (cyc == 2);
                in_data = (widx < n) ? words[widx] : 64'hBAD0_BAD0_BAD0_BAD0;
                out_ready = r.toggle ? ~out_ready : 1'b1;
                if (!r.early && run_k >= 0) begin
                    run_k++;
                    case (run_k)
                        1: begin
                            acc_write_en = 1'b1; acc_addr = 32'h3A0; acc_data_in = YW;
                            exp_wr.push_back({32'h3A0, YW});
                        end
                        2: begin acc_write_en = 1'b0; acc_addr = 32'h3A8; end
                        3: acc_done = 1'b1;
                        4: begin acc_write_en = 1'b1; acc_addr = 32'h3B0; acc_data_in = '1; end
                        default: ;
                    endcase
                end
            end
        end
        if (!seen_done) begin
            checks++; errors++;
            $display("FAIL done_timeout actual=none required=done rec=%0d", idx);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; acc_write_en = 1'b0; start = 1'b0;
        @(negedge clk);
        check64("post_done_idle", 64'({done, busy}), 64'd0);
        check64("acc_start_pulses", 64'(acc_start_total - a0), 64'd1);
        exp_wr.delete();
        exp_out.delete();
        @(posedge clk); #1;
    endtask

    rec_t tbl[9];
    bit   got;

    initial begin
        rst = 1'b1; start = 1'b0; in_words = '0; out_words = '0;
        input_base = '0; output_base = '0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0; acc_done = 1'b0; acc_write_en = 1'b0; acc_addr = '0;
        acc_data_in = '0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        #12;
        check_idle_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        //          in    out  in_base        out_base     tg ea p2 lat   last write
        tbl[0] = mk(4,    2,   32'h100,       32'h200,     0, 1, 0, 10,   32'h103);
        tbl[1] = mk(1,    3,   32'h140,       32'h210,     1, 1, 0, 0,    32'h140);
        tbl[2] = mk(0,    0,   32'h0,         32'h0,       0, 1, 0, 3,    32'h0);
        tbl[3] = mk(4,    1,   32'hFFFFFFFE,  32'h300,     0, 1, 0, 9,    32'h1);
        tbl[4] = mk(0,    4,   32'h0,         32'h240,     0, 1, 0, 8,    32'h0);
        tbl[5] = mk(3,    0,   32'h160,       32'h0,       0, 1, 0, 6,    32'h162);
        tbl[6] = mk(3,    2,   32'h170,       32'h2C0,     0, 1, 1, 9,    32'h172);
        tbl[7] = mk(2,    2,   32'h180,       32'h260,     0, 0, 0, 0,    32'h3A0);
        tbl[8] = mk(4096, 0,   32'h0,         32'h0,       0, 1, 0, 4099, 32'hFFF);
        for (int k = 0; k < 9; k++) run_seq(tbl[k], k);

        // Reset while results are waiting in the read FIFO.
        for (int i = 0; i < 3; i++) preload(32'h280 + 32'(i), 64'hEE00 + 64'(i));
        in_words = '0; out_words = CW'(3); output_base = 32'h280;
        acc_done = 1'b1; out_ready = 1'b0; in_valid = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = out_valid;
        end
        check64("abort_fifo_filled", 64'(got), 64'd1);
        #2 rst = 1'b1;
        #1 check_idle_outputs("abort");
        @(posedge clk); #1;
        rst = 1'b0;
        got = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            got = got | done | busy;
        end
        check64("abort_no_done", 64'(got), 64'd0);
        @(posedge clk); #1;
        run_seq(tbl[0], 9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
